tff_mod_counter: RTL and testbench

Parametrised successor to the single-bit toggle flip-flop. It is a WIDTH-bit register whose bits can be toggled by mask, counted up or down modulo MOD, or loaded. It produces terminal-count and illegal-toggle pulses. It is used as a general event counter / divider / toggle bank in sequential datapaths.

---
 rtl/tff_mod_counter.sv | 158 +++++++++++++++
 tb/tb_tff_mod_counter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_mod_counter.sv
// ---------------------------------------------------------------------------
// tff_mod_counter
//
// WIDTH-bit state register that can toggle bits by mask, count up or down
// modulo MOD, or be loaded. A terminal-count pulse marks each up/down wrap
// (or each attempted step past a limit when saturating). An illegal-toggle
// pulse marks a masked toggle that would leave the legal range 0..MOD-1.
//
// Parameters
//   The register width WIDTH may be 1..32 bits.
//   The count modulus may be 2..2^WIDTH; q always stays in 0..MOD-1.
//   SATURATE selects wrapping (0) or holding (1) at the limits.
//
// Ports
//   clk   in   rising-edge clock
//   rstn  in   asynchronous active-low reset (q=0, tc=0, err=0)
//   en    in   count/toggle enable (load does not need it)
//   mode  in   2'b00 hold, 2'b01 up, 2'b10 down, 2'b11 toggle-mask
//   load  in   synchronous load of din, highest priority, clamped to MOD-1
//   din   in   load value
//   tmask in   per-bit toggle enables used in toggle mode
//   q     out  registered state
//   qbar  out  bitwise complement of q
//   tc    out  registered terminal-count pulse
//   err   out  registered illegal-toggle pulse
// ---------------------------------------------------------------------------
module tff_mod_counter #(
    parameter int     WIDTH    = 8,
    parameter longint MOD      = 256,
    parameter int     SATURATE = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] tmask,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             err
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    // Comparisons are done one bit wider so that MOD = 2^WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 64'd1);
    localparam logic             SAT_L = (SATURATE != 0) ? 1'b1 : 1'b0;

    // True when a WIDTH-bit value lies inside the legal range 0..MOD-1.
    function automatic logic in_range(input logic [WIDTH-1:0] v);
        return ({1'b0, v} < MOD_W);
    endfunction

    // Load value clamped to the top of the legal range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (in_range(v)) begin
            r = v;
        end else begin
            r = MAX_Q;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             err_r;

    logic [WIDTH-1:0] q_next_s;
    logic             tc_next_s;
    logic             err_next_s;
    logic [WIDTH-1:0] cand_s;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);
    assign cand_s = q_r ^ tmask;

    // Next-state selection in priority order: load, idle, up, down, toggle.
    always_comb begin
        q_next_s   = q_r;
        tc_next_s  = 1'b0;
        err_next_s = 1'b0;
        if (load) begin
            q_next_s = clamp_load(din);
        end else if (!en) begin
            q_next_s = q_r;
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    q_next_s = q_r;
                end
                MODE_UP: begin
                    if (q_r == MAX_Q) begin
                        tc_next_s = 1'b1;
                        if (SAT_L) begin
                            q_next_s = q_r;
                        end else begin
                            q_next_s = {WIDTH{1'b0}};
                        end
                    end else begin
                        q_next_s = q_r + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (q_r == {WIDTH{1'b0}}) begin
                        tc_next_s = 1'b1;
                        if (SAT_L) begin
                            q_next_s = q_r;
                        end else begin
                            q_next_s = MAX_Q;
                        end
                    end else begin
                        q_next_s = q_r - WIDTH'(1);
                    end
                end
                MODE_TOGGLE: begin
                    // A toggle that would leave the legal range is refused.
                    if (in_range(cand_s)) begin
                        q_next_s = cand_s;
                    end else begin
                        q_next_s   = q_r;
                        err_next_s = 1'b1;
                    end
                end
                default: begin
                    q_next_s = q_r;
                end
            endcase
        end
    end

    // State and pulse registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_r   <= {WIDTH{1'b0}};
            tc_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            q_r   <= q_next_s;
            tc_r  <= tc_next_s;
            err_r <= err_next_s;
        end
    end

    assign q    = q_r;
    assign qbar = ~q_r;
    assign tc   = tc_r;
    assign err  = err_r;

endmodule

// File: tb/tb_tff_mod_counter.sv
// ---------------------------------------------------------------------------
// Testbench for tff_mod_counter. Four instances share one stimulus stream:
//   0: WIDTH=8 MOD=10  wrap       1: WIDTH=8 MOD=10  saturate
//   2: WIDTH=4 MOD=16  wrap       3: WIDTH=8 MOD=256 wrap
// A behavioural integer model tracks each instance and is compared with the
// DUT outputs every cycle; directed scenarios add hand-computed literals.
// ---------------------------------------------------------------------------
module tb_tff_mod_counter;

    typedef struct packed {
        logic [31:0] q;
        logic        tc;
        logic        err;
    } mres_t;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [7:0] din;
    logic [7:0] tmask;

    logic [7:0] q_a, qb_a, q_b, qb_b, q_d, qb_d;
    logic [3:0] q_c, qb_c;
    logic       tc_a, err_a, tc_b, err_b, tc_c, err_c, tc_d, err_d;

    int n_chk  = 0;
    int n_fail = 0;

    int mod_p [4] = '{10, 10, 16, 256};
    int sat_p [4] = '{0, 1, 0, 0};
    int w_p   [4] = '{8, 8, 4, 8};

    int mq   [4];
    bit mtc  [4];
    bit merr [4];

    logic [31:0] dq [4];
    logic [31:0] dqb[4];
    logic        dtc[4];
    logic        derr[4];

    tff_mod_counter #(.WIDTH(8), .MOD(10), .SATURATE(0)) u_a (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .load(load),
        .din(din), .tmask(tmask), .q(q_a), .qbar(qb_a), .tc(tc_a), .err(err_a));
    tff_mod_counter #(.WIDTH(8), .MOD(10), .SATURATE(1)) u_b (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .load(load),
        .din(din), .tmask(tmask), .q(q_b), .qbar(qb_b), .tc(tc_b), .err(err_b));
    tff_mod_counter #(.WIDTH(4), .MOD(16), .SATURATE(0)) u_c (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .load(load),
        .din(din[3:0]), .tmask(tmask[3:0]), .q(q_c), .qbar(qb_c), .tc(tc_c), .err(err_c));
    tff_mod_counter #(.WIDTH(8), .MOD(256), .SATURATE(0)) u_d (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .load(load),
        .din(din), .tmask(tmask), .q(q_d), .qbar(qb_d), .tc(tc_d), .err(err_d));

    assign dq[0] = {24'd0, q_a};  assign dqb[0] = {24'd0, qb_a};
    assign dq[1] = {24'd0, q_b};  assign dqb[1] = {24'd0, qb_b};
    assign dq[2] = {28'd0, q_c};  assign dqb[2] = {28'd0, qb_c};
    assign dq[3] = {24'd0, q_d};  assign dqb[3] = {24'd0, qb_d};
    assign dtc[0] = tc_a; assign dtc[1] = tc_b; assign dtc[2] = tc_c; assign dtc[3] = tc_d;
    assign derr[0] = err_a; assign derr[1] = err_b; assign derr[2] = err_c; assign derr[3] = err_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: one clock edge of the counter, from the rules.
    function automatic mres_t model_next(input int q, input int modv, input int sat,
                                         input int w, input bit ld, input bit e,
                                         input bit [1:0] md, input int d, input int tm);
        mres_t r;
        int    mask;
        int    c;
        mask  = (1 << w) - 1;
        r.q   = q;
        r.tc  = 1'b0;
        r.err = 1'b0;
        if (ld) begin
            r.q = ((d & mask) < modv) ? (d & mask) : (modv - 1);
        end else if (!e || md == 2'd0) begin
            r.q = q;
        end else if (md == 2'd1) begin
            if (q == modv - 1) begin
                r.tc = 1'b1;
                r.q  = (sat != 0) ? q : 0;
            end else begin
                r.q = q + 1;
            end
        end else if (md == 2'd2) begin
            if (q == 0) begin
                r.tc = 1'b1;
                r.q  = (sat != 0) ? q : (modv - 1);
            end else begin
                r.q = q - 1;
            end
        end else begin
            c = q ^ (tm & mask);
            if (c < modv) r.q = c;
            else r.err = 1'b1;
        end
        return r;
    endfunction

    // Model state, advanced on every edge and cleared by reset.
    always @(posedge clk or negedge rstn) begin
        for (int i = 0; i < 4; i++) begin
            if (!rstn) begin
                mq[i]   <= 0;
                mtc[i]  <= 1'b0;
                merr[i] <= 1'b0;
            end else begin
                mres_t r;
                r = model_next(mq[i], mod_p[i], sat_p[i], w_p[i], load, en, mode,
                               int'(din), int'(tmask));
                mq[i]   <= int'(r.q);
                mtc[i]  <= r.tc;
                merr[i] <= r.err;
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Compare every instance against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("inst%0d_q", i),    longint'(dq[i]),   longint'(mq[i]));
            check($sformatf("inst%0d_qbar", i), longint'(dqb[i]),
                  longint'((~mq[i]) & ((1 << w_p[i]) - 1)));
            check($sformatf("inst%0d_tc", i),   longint'(dtc[i]),  longint'(mtc[i]));
            check($sformatf("inst%0d_err", i),  longint'(derr[i]), longint'(merr[i]));
        end
    end

    // One clock edge; inputs were set before, outputs are stable on return.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit ld, input bit e, input bit [1:0] md,
                         input logic [7:0] d, input logic [7:0] tm);
        load  = ld;
        en    = e;
        mode  = md;
        din   = d;
        tmask = tm;
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
        cyc();
        cyc();
        check("reset_q_a", q_a, 8'd0);
        check("reset_qbar_a", qb_a, 8'hFF);
        check("reset_tc_a", tc_a, 1'b0);
        check("reset_err_a", err_a, 1'b0);
        rstn = 1'b1;

        // Async reset in the middle of a count (MOD=256 instance).
        drive(1'b1, 1'b0, 2'b00, 8'h10, 8'd0);
        cyc();
        drive(1'b0, 1'b1, 2'b01, 8'h00, 8'd0);
        repeat (5) cyc();
        check("async_pre_q_d", q_d, 8'h15);
        #2;
        rstn = 1'b0;
        #1;
        check("async_q_d", q_d, 8'h00);
        check("async_qbar_d", qb_d, 8'hFF);
        check("async_tc_d", tc_d, 1'b0);
        check("async_err_d", err_d, 1'b0);
        cyc();
        rstn = 1'b1;
        drive(1'b0, 1'b0, 2'b01, 8'h00, 8'd0);
        cyc();
        check("release_hold_q_d", q_d, 8'h00);
        en = 1'b1;
        cyc();
        check("release_first_q_d", q_d, 8'h01);

        // Wrap up then down, MOD=10.
        drive(1'b1, 1'b0, 2'b00, 8'd8, 8'd0);
        cyc();
        drive(1'b0, 1'b1, 2'b01, 8'd0, 8'd0);
        cyc(); check("wrap_up1_q", q_a, 8'd9); check("wrap_up1_tc", tc_a, 1'b0);
        cyc(); check("wrap_up2_q", q_a, 8'd0); check("wrap_up2_tc", tc_a, 1'b1);
        cyc(); check("wrap_up3_q", q_a, 8'd1); check("wrap_up3_tc", tc_a, 1'b0);
        mode = 2'b10;
        cyc(); check("wrap_dn1_q", q_a, 8'd0); check("wrap_dn1_tc", tc_a, 1'b0);
        cyc(); check("wrap_dn2_q", q_a, 8'd9); check("wrap_dn2_tc", tc_a, 1'b1);

        // Saturation, MOD=10.
        drive(1'b1, 1'b0, 2'b00, 8'd9, 8'd0);
        cyc();
        drive(1'b0, 1'b1, 2'b01, 8'd0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("sat_up_q", q_b, 8'd9);
            check("sat_up_tc", tc_b, 1'b1);
        end
        drive(1'b1, 1'b1, 2'b01, 8'd0, 8'd0);
        cyc(); check("sat_load0_q", q_b, 8'd0); check("sat_load0_tc", tc_b, 1'b0);
        drive(1'b0, 1'b1, 2'b10, 8'd0, 8'd0);
        cyc(); check("sat_dn_q", q_b, 8'd0); check("sat_dn_tc", tc_b, 1'b1);

        // Toggle and illegal toggle, MOD=10.
        drive(1'b1, 1'b0, 2'b00, 8'd3, 8'd0);
        cyc();
        drive(1'b0, 1'b1, 2'b11, 8'd0, 8'b0101);
        cyc(); check("tog_q", q_a, 8'd6); check("tog_err", err_a, 1'b0);
        tmask = 8'b1000;
        cyc(); check("tog_bad_q", q_a, 8'd6); check("tog_bad_err", err_a, 1'b1);
        tmask = 8'd0;
        cyc(); check("tog_zero_q", q_a, 8'd6); check("tog_zero_err", err_a, 1'b0);

        // Load priority and clamping.
        drive(1'b1, 1'b0, 2'b00, 8'h0C, 8'd0);
        cyc(); check("clamp_q", q_a, 8'd9);
        drive(1'b1, 1'b1, 2'b01, 8'd4, 8'd0);
        cyc(); check("prio_q", q_a, 8'd4); check("prio_tc", tc_a, 1'b0);
        drive(1'b0, 1'b0, 2'b01, 8'd0, 8'd0);
        repeat (4) cyc();
        check("en_low_q", q_a, 8'd4);

        // Full-range modulus, WIDTH=4 MOD=16.
        drive(1'b1, 1'b0, 2'b00, 8'd15, 8'd0);
        cyc();
        drive(1'b0, 1'b1, 2'b01, 8'd0, 8'd0);
        cyc(); check("full_wrap_q", q_c, 4'd0); check("full_wrap_tc", tc_c, 1'b1);
        drive(1'b1, 1'b0, 2'b00, 8'd5, 8'd0);
        cyc();
        drive(1'b0, 1'b1, 2'b11, 8'd0, 8'h0F);
        cyc(); check("full_tog_q", q_c, 4'd10); check("full_tog_err", err_c, 1'b0);
        check("full_tog_qbar", qb_c, 4'd5);

        // Randomised traffic, compared against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = 2'($urandom_range(0, 3));
            din   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20))
                                                : 8'($urandom_range(0, 255));
            tmask = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                                : 8'($urandom_range(0, 255));
            if (i == 200) rstn = 1'b0;
            if (i == 202) rstn = 1'b1;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
